// File: rtl/ysyx_l1d_pkg.sv
// Shared types and width helpers for the ysyx L1 data cache.
package ysyx_l1d_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_AR,
    S_R,
    S_W,
    S_RESP
  } state_e;

  localparam logic [31:0] UC_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] UC_MASK_DEF = 32'hF000_0000;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int tag_w(input int addr_w, input int idx_w, input int data_w);
    return addr_w - idx_w - off_w(data_w);
  endfunction

endpackage

// File: rtl/ysyx_l1d_array.sv
// Tag/valid/data storage: async read, one byte-masked write port, single-cycle valid clear.
module ysyx_l1d_array
  import ysyx_l1d_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 24,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int DEPTH  = 2 ** IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic              wr_fill,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_be
);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

  // Data and tags carry no reset; only the valid bits need a known state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_be[b]) data_mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
      if (wr_fill) tag_mem[wr_idx] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1D with MMIO bypass, flush and perf counters.
//   state  | meaning
//   IDLE   | accept request / apply flush
//   LOOKUP | tag compare; load hit responds here
//   AR     | bus read address handshake
//   R      | wait read data, fill cacheable line
//   W      | bus write, merge into line on hit
//   RESP   | completion pulse for bus-served requests
module ysyx_l1d_cache
  import ysyx_l1d_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6,
  parameter logic [ADDR_W-1:0] UC_BASE = ADDR_W'(UC_BASE_DEF),
  parameter logic [ADDR_W-1:0] UC_MASK = ADDR_W'(UC_MASK_DEF),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] bus_araddr,
  output logic              bus_arvalid,
  input  logic              bus_arready,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [ADDR_W-1:0] bus_awaddr,
  output logic              bus_awvalid,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
);

  localparam int OFF_W = off_w(DATA_W);
  localparam int TAG_W = tag_w(ADDR_W, IDX_W, DATA_W);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(STRB_W - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              flush_pend;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              uc;
  logic              hit;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;

  logic              accept;
  logic              capture;
  logic              cnt_hit;
  logic              cnt_miss;
  logic              clear_all;
  logic              arr_wr;
  logic              arr_fill;
  logic [DATA_W-1:0] arr_wdata;
  logic [STRB_W-1:0] arr_be;

  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign uc  = (addr_q & UC_MASK) == UC_BASE;
  assign hit = line_valid && (line_tag == tag) && !uc;

  // addr_q is stored word-aligned, so the bus addresses come straight from it.
  assign bus_araddr = addr_q;
  assign bus_awaddr = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;

  ysyx_l1d_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all (clear_all),
    .rd_idx    (idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (arr_wr && rst_n),
    .wr_fill   (arr_fill),
    .wr_idx    (idx),
    .wr_tag    (tag),
    .wr_data   (arr_wdata),
    .wr_be     (arr_be)
  );

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    bus_arvalid = 1'b0;
    bus_awvalid = 1'b0;
    bus_wvalid  = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    cnt_hit     = 1'b0;
    cnt_miss    = 1'b0;
    clear_all   = 1'b0;
    arr_wr      = 1'b0;
    arr_fill    = 1'b0;
    arr_wdata   = wdata_q;
    arr_be      = wstrb_q;
    case (state_q)
      S_IDLE: begin
        clear_all = flush || flush_pend;
        req_ready = !flush && !flush_pend;
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (wen_q) begin
          state_d = S_W;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = line_data;
          cnt_hit    = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_miss = !uc;
          state_d  = S_AR;
        end
      end
      S_AR: begin
        bus_arvalid = 1'b1;
        if (bus_arready) state_d = S_R;
      end
      S_R: begin
        if (bus_rvalid) begin
          capture = 1'b1;
          if (!uc) begin
            arr_wr    = 1'b1;
            arr_fill  = 1'b1;
            arr_wdata = bus_rdata;
            arr_be    = '1;
          end
          state_d = S_RESP;
        end
      end
      S_W: begin
        bus_awvalid = 1'b1;
        bus_wvalid  = 1'b1;
        if (bus_wready) begin
          arr_wr  = hit;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = wen_q ? '0 : rdata_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      flush_pend <= 1'b0;
      perf_hit   <= '0;
      perf_miss  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr & WORD_MASK;
        wen_q   <= req_wen;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (capture) rdata_q <= bus_rdata;
      // A flush seen mid-transaction is held until the next IDLE cycle consumes it.
      if (state_q == S_IDLE) flush_pend <= 1'b0;
      else if (flush)        flush_pend <= 1'b1;
      if (cnt_hit && perf_hit != 32'hFFFF_FFFF)   perf_hit  <= perf_hit + 32'd1;
      if (cnt_miss && perf_miss != 32'hFFFF_FFFF) perf_miss <= perf_miss + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_l1d_cache.sv
// Self-checking bench for ysyx_l1d_cache: directed vector table, corner sequences, random vs reference model.
module tb_ysyx_l1d_cache;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wen, flush, resp_valid;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wstrb, bus_wstrb;
  logic [31:0] bus_araddr, bus_awaddr, bus_wdata, perf_hit, perf_miss;
  logic        bus_arvalid, bus_awvalid, bus_wvalid;
  logic        bus_arready = 1'b0;
  logic        bus_rvalid  = 1'b0;
  logic        bus_wready  = 1'b0;
  logic [31:0] bus_rdata   = 32'h0;

  int checks = 0;
  int failures = 0;

  ysyx_l1d_cache dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .bus_araddr  (bus_araddr),
    .bus_arvalid (bus_arvalid),
    .bus_arready (bus_arready),
    .bus_rdata   (bus_rdata),
    .bus_rvalid  (bus_rvalid),
    .bus_awaddr  (bus_awaddr),
    .bus_awvalid (bus_awvalid),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_wvalid  (bus_wvalid),
    .bus_wready  (bus_wready),
    .perf_hit    (perf_hit),
    .perf_miss   (perf_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- memories: reference image and the image the bus model serves
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  function automatic void ensure(input logic [31:0] a);
    logic [31:0] v;
    if (!ref_mem.exists(a)) begin
      v = $urandom;
      ref_mem[a] = v;
      bus_mem[a] = v;
    end
  endfunction

  function automatic void preset(input logic [31:0] a, input logic [31:0] v);
    ref_mem[a] = v;
    bus_mem[a] = v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // ---------------- reference cache model (64 lines, word lines, tag = addr[31:8])
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  int          m_hit, m_miss;

  function automatic logic is_uc(input logic [31:0] a);
    return (a & 32'hF000_0000) == 32'h1000_0000;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic logic model_hits(input logic [31:0] addr);
    int i = int'(addr[7:2]);
    return !is_uc(addr) && m_valid[i] && (m_tag[i] == addr[31:8]);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr);
    logic [31:0] a = addr & ~32'h3;
    int i = int'(a[7:2]);
    if (model_hits(a)) begin
      m_hit++;
      return m_data[i];
    end
    ensure(a);
    if (!is_uc(a)) begin
      m_miss++;
      m_valid[i] = 1'b1;
      m_tag[i]   = a[31:8];
      m_data[i]  = ref_mem[a];
    end
    return ref_mem[a];
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [3:0] st);
    logic [31:0] a = addr & ~32'h3;
    int i = int'(a[7:2]);
    ensure(a);
    ref_mem[a] = merge(ref_mem[a], wd, st);
    if (model_hits(a)) m_data[i] = merge(m_data[i], wd, st);
  endfunction

  // ---------------- bus responder (drives on negedge)
  int          bus_wait_max = 0;
  int          force_ar = -1;
  int          force_r  = -1;
  int          ar_cnt = -1, r_cnt = 0, w_cnt = -1;
  logic        r_pend = 1'b0;
  logic [31:0] r_addr;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_araddr = 32'h0, last_awaddr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;

  function automatic int pick(input int forced);
    if (forced >= 0) return forced;
    return int'($urandom_range(bus_wait_max, 0));
  endfunction

  always @(negedge clk) begin
    bus_arready = 1'b0;
    bus_rvalid  = 1'b0;
    bus_wready  = 1'b0;
    if (!rst_n) begin
      r_pend = 1'b0;
      ar_cnt = -1;
      w_cnt  = -1;
    end else begin
      if (bus_arvalid && !r_pend) begin
        if (ar_cnt < 0) ar_cnt = pick(force_ar);
        if (ar_cnt == 0) begin
          bus_arready = 1'b1;
          r_addr      = bus_araddr;
          last_araddr = bus_araddr;
          r_pend      = 1'b1;
          r_cnt       = pick(force_r);
          ar_cnt      = -1;
          rd_cnt++;
        end else ar_cnt--;
      end else if (r_pend && !bus_arvalid) begin
        if (r_cnt == 0) begin
          ensure(r_addr);
          bus_rvalid = 1'b1;
          bus_rdata  = bus_mem[r_addr];
          r_pend     = 1'b0;
        end else r_cnt--;
      end
      if (bus_awvalid && bus_wvalid) begin
        if (w_cnt < 0) w_cnt = pick(-1);
        if (w_cnt == 0) begin
          bus_wready = 1'b1;
          ensure(bus_awaddr);
          bus_mem[bus_awaddr] = merge(bus_mem[bus_awaddr], bus_wdata, bus_wstrb);
          last_awaddr = bus_awaddr;
          last_wdata  = bus_wdata;
          last_wstrb  = bus_wstrb;
          w_cnt = -1;
          wr_cnt++;
        end else w_cnt--;
      end
    end
  end

  // ---------------- request driver; lat = cycles from accept edge to resp_valid
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rdata, output int lat);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = st;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 60);
    check("resp_valid_seen", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] base;
    int unsigned sel = $urandom_range(7, 0);
    case (sel)
      0:       base = 32'h1000_0000;
      1, 2:    base = 32'h8000_0000;
      3, 4:    base = 32'h8000_0100;
      5:       base = 32'h8000_1000;
      default: base = 32'h2000_0000;
    endcase
    return base + 32'($urandom_range(3, 0)) * 32'd4 + 32'($urandom_range(3, 0));
  endfunction

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rdata, exp, a;
    logic        exp_hit;
    int          lat, rd0, wr0, guard;

    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; flush = 1'b0;
    model_clear();
    m_hit = 0;
    m_miss = 0;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_arvalid", 32'(bus_arvalid), 32'd0);
    check("rst_awvalid", 32'(bus_awvalid), 32'd0);
    check("rst_wvalid", 32'(bus_wvalid), 32'd0);
    check("rst_araddr", bus_araddr, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_hit", perf_hit, 32'd0);
    check("post_rst_miss", perf_miss, 32'd0);

    // ---------------- directed table, zero-wait bus
    preset(32'h8000_0010, 32'hDEAD_BEEF);
    preset(32'h8000_0110, 32'h1234_5678);
    preset(32'h1000_0000, 32'hCAFE_F00D);
    preset(32'h1000_0004, 32'h0000_0000);
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 4, 1, 0});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1, 0, 0});
    vecs.push_back('{1'b1, 32'h8000_0010, 32'h0000_AB00, 4'h2, 32'h0,         3, 0, 1});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 1, 0, 0});
    vecs.push_back('{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_ABEF, 1, 0, 0});
    vecs.push_back('{1'b0, 32'h1000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 4, 1, 0});
    vecs.push_back('{1'b0, 32'h1000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 4, 1, 0});
    vecs.push_back('{1'b0, 32'h8000_0110, 32'h0,         4'h0, 32'h1234_5678, 4, 1, 0});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 4, 1, 0});
    vecs.push_back('{1'b1, 32'h8000_0212, 32'h1122_3344, 4'hF, 32'h0,         3, 0, 1});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 1, 0, 0});
    vecs.push_back('{1'b1, 32'h1000_0004, 32'hA5A5_A5A5, 4'h9, 32'h0,         3, 0, 1});
    vecs.push_back('{1'b0, 32'h1000_0004, 32'h0,         4'h0, 32'hA500_00A5, 4, 1, 0});

    foreach (vecs[i]) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      if (vecs[i].wen) model_store(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      else exp = model_load(vecs[i].addr);
      do_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rdata, lat);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_bus_reads", i), 32'(rd_cnt - rd0), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_bus_writes", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_rd > 0)
        check($sformatf("vec%0d_araddr", i), last_araddr, vecs[i].addr & ~32'h3);
      if (vecs[i].wen) begin
        check($sformatf("vec%0d_awaddr", i), last_awaddr, vecs[i].addr & ~32'h3);
        check($sformatf("vec%0d_wstrb", i), 32'(last_wstrb), 32'(vecs[i].wstrb));
      end
    end
    check("dir_perf_hit", perf_hit, 32'd4);
    check("dir_perf_miss", perf_miss, 32'd3);

    // ---------------- flush latched while waiting in R
    force_r = 5;
    exp = model_load(32'h8000_0310);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0310;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("flushR_resp_valid", 32'(resp_valid), 32'd1);
    check("flushR_rdata", resp_rdata, exp);
    @(negedge clk);
    check("flushR_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("flushR_ready_back", 32'(req_ready), 32'd1);
    model_clear();
    force_r = -1;
    exp = model_load(32'h8000_0310);
    do_req(1'b0, 32'h8000_0310, 32'h0, 4'h0, rdata, lat);
    check("flushR_reload_data", rdata, exp);
    check("flushR_reload_lat", 32'(lat), 32'd4);

    // ---------------- reset while holding AR
    force_ar = 10;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0410;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstAR_arvalid_high", 32'(bus_arvalid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstAR_arvalid_low", 32'(bus_arvalid), 32'd0);
    check("rstAR_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    force_ar = -1;
    model_clear();
    m_hit = 0;
    m_miss = 0;
    @(negedge clk);
    check("rstAR_perf_miss", perf_miss, 32'd0);
    exp = model_load(32'h8000_0010);
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, rdata, lat);
    check("rstAR_reload_data", rdata, exp);
    check("rstAR_reload_lat", 32'(lat), 32'd4);

    // ---------------- randomized traffic against the model
    bus_wait_max = 2;
    for (int n = 0; n < 400; n++) begin
      int unsigned op = $urandom_range(99, 0);
      if (op < 6) begin
        a = gen_addr() & ~32'h3;
        preset(a, $urandom);
      end else if (op < 10) begin
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("rnd_flush_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end else if (op < 45) begin
        logic [31:0] wd = $urandom;
        logic [3:0]  st = 4'($urandom_range(15, 0));
        a = gen_addr();
        wr0 = wr_cnt;
        model_store(a, wd, st);
        do_req(1'b1, a, wd, st, rdata, lat);
        check("rnd_store_rdata", rdata, 32'h0);
        check("rnd_store_writes", 32'(wr_cnt - wr0), 32'd1);
        check("rnd_store_awaddr", last_awaddr, a & ~32'h3);
        check("rnd_store_wstrb", 32'(last_wstrb), 32'(st));
        check("rnd_store_wdata", last_wdata, wd);
      end else begin
        a = gen_addr();
        rd0 = rd_cnt;
        exp_hit = model_hits(a);
        exp = model_load(a);
        do_req(1'b0, a, 32'h0, 4'h0, rdata, lat);
        check("rnd_load_data", rdata, exp);
        check("rnd_load_hit", 32'(lat == 1), 32'(exp_hit));
        check("rnd_load_reads", 32'(rd_cnt - rd0), exp_hit ? 32'd0 : 32'd1);
      end
    end
    @(negedge clk);
    check("rnd_perf_hit", perf_hit, 32'(m_hit));
    check("rnd_perf_miss", perf_miss, 32'(m_miss));
    foreach (ref_mem[k]) check($sformatf("mem_%h", k), bus_mem[k], ref_mem[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
